// File: rtl/mem_arb_if.sv
// Request/response port bundle shared by the fetch, LSU and unified memory sides of mem_arb.
// master drives address/masks/store data; slave returns read data and the response pulse.
`default_nettype none

interface mem_arb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned MASK_W = DATA_W / 8;

  logic [ADDR_W-1:0] addr;
  logic [MASK_W-1:0] rmask;
  logic [MASK_W-1:0] wmask;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              resp;

  modport master (
    output addr,
    output rmask,
    output wmask,
    output wdata,
    input  rdata,
    input  resp
  );

  modport slave (
    input  addr,
    input  rmask,
    input  wmask,
    input  wdata,
    output rdata,
    output resp
  );
endinterface

`default_nettype wire

// File: rtl/mem_arb.sv
// Merges the core's fetch (imem) and LSU (dmem) ports onto one memory port, one request in flight.
// Default: fixed D priority with MAX_D_STREAK anti-starvation; define ARB_RR_EN for round robin.
`default_nettype none

module mem_arb #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  imem,
  mem_arb_if.slave  dmem,
  mem_arb_if.master mem
);

  localparam int unsigned MASK_W   = DATA_W / 8;
  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] rmask;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   pend_i_q, pend_i_d;
  logic   pend_d_q, pend_d_d;
  req_t   req_i_q, req_i_d;
  req_t   req_d_q, req_d_d;
  req_t   issue_q, issue_d;

`ifdef ARB_RR_EN
  logic last_i_q, last_i_d;
`else
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                streak_full;
`endif

  logic in_i, in_d;
  logic cand_i, cand_d;
  logic grant_en;
  logic win_i, win_d;
  req_t inc_i, inc_d;
  req_t sel_i, sel_d;

  // A pulse this cycle competes directly; otherwise the latched copy does.
  always_comb begin
    inc_i.addr  = imem.addr;
    inc_i.rmask = imem.rmask;
    inc_i.wmask = imem.wmask;
    inc_i.wdata = imem.wdata;
    inc_d.addr  = dmem.addr;
    inc_d.rmask = dmem.rmask;
    inc_d.wmask = dmem.wmask;
    inc_d.wdata = dmem.wdata;

    in_i   = (|imem.rmask) | (|imem.wmask);
    in_d   = (|dmem.rmask) | (|dmem.wmask);
    cand_i = pend_i_q | in_i;
    cand_d = pend_d_q | in_d;
    sel_i  = in_i ? inc_i : req_i_q;
    sel_d  = in_d ? inc_d : req_d_q;

    // Arbitrate when idle, or back-to-back on the response of the request in flight.
    grant_en = (state_q == IDLE) | mem.resp;
  end

`ifdef ARB_RR_EN
  // On a collision the side that did not win last time goes first.
  always_comb begin
    win_i = cand_i & (~cand_d | ~last_i_q);
    win_d = cand_d & ~win_i;
  end
`else
  // D first, unless it has already taken MAX_D_STREAK grants past a waiting I.
  always_comb begin
    streak_full = (streak_q == STREAK_W'(MAX_D_STREAK));
    win_d       = cand_d & (~cand_i | ~streak_full);
    win_i       = cand_i & ~win_d;
  end
`endif

  // Next-state, capture and issue logic.
  always_comb begin
    state_d  = state_q;
    pend_i_d = pend_i_q;
    pend_d_d = pend_d_q;
    req_i_d  = req_i_q;
    req_d_d  = req_d_q;
    issue_d  = '0;
`ifdef ARB_RR_EN
    last_i_d = last_i_q;
`else
    streak_d = streak_q;
`endif

    if (grant_en) begin
      if (win_i) begin
        state_d = WAIT_I;
        issue_d = sel_i;
      end else if (win_d) begin
        state_d = WAIT_D;
        issue_d = sel_d;
      end else begin
        state_d = IDLE;
      end
    end

    if (grant_en && win_i) begin
      pend_i_d = 1'b0;
    end else if (in_i) begin
      pend_i_d = 1'b1;
      req_i_d  = inc_i;
    end

    if (grant_en && win_d) begin
      pend_d_d = 1'b0;
    end else if (in_d) begin
      pend_d_d = 1'b1;
      req_d_d  = inc_d;
    end

`ifdef ARB_RR_EN
    if (grant_en && (win_i || win_d)) begin
      last_i_d = win_i;
    end
`else
    if (grant_en && win_i) begin
      streak_d = '0;
    end else if (grant_en && win_d && cand_i && !streak_full) begin
      streak_d = streak_q + STREAK_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pend_i_q <= 1'b0;
      pend_d_q <= 1'b0;
      req_i_q  <= '0;
      req_d_q  <= '0;
      issue_q  <= '0;
`ifdef ARB_RR_EN
      last_i_q <= 1'b1;
`else
      streak_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pend_i_q <= pend_i_d;
      pend_d_q <= pend_d_d;
      req_i_q  <= req_i_d;
      req_d_q  <= req_d_d;
      issue_q  <= issue_d;
`ifdef ARB_RR_EN
      last_i_q <= last_i_d;
`else
      streak_q <= streak_d;
`endif
    end
  end

  assign mem.addr  = issue_q.addr;
  assign mem.rmask = issue_q.rmask;
  assign mem.wmask = issue_q.wmask;
  assign mem.wdata = issue_q.wdata;

  // Responses steer combinationally; a response with nothing in flight is dropped.
  assign imem.resp  = mem.resp & (state_q == WAIT_I);
  assign dmem.resp  = mem.resp & (state_q == WAIT_D);
  assign imem.rdata = mem.rdata;
  assign dmem.rdata = mem.rdata;

  // A side may only re-request once its previous request has been answered.
  a_imem_one_outstanding : assert property (@(posedge clk) disable iff (!rst)
    in_i |-> !(pend_i_q || ((state_q == WAIT_I) && !mem.resp)));

  a_dmem_one_outstanding : assert property (@(posedge clk) disable iff (!rst)
    in_d |-> !(pend_d_q || ((state_q == WAIT_D) && !mem.resp)));

  a_dmem_rw_exclusive : assert property (@(posedge clk) disable iff (!rst)
    !((|dmem.rmask) && (|dmem.wmask)));

endmodule

`default_nettype wire
